// File: rtl/serial_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
//   addsub_state_t     : control states of serial_addsub
//   DEFAULT_DATA_WIDTH : default operand/result width
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } addsub_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/serial_addsub_full_adder.sv
// Single-bit combinational full adder used on the serial bit path.
//   a, b, cin : operand bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Subtraction is a + ~b + 1: b is inverted when latched and the carry starts at 1.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake (in_ready high only while idle)
//   a, b, sub            : operands and operation select (0: a+b, 1: a-b)
//   out_valid, out_ready : result handshake (result held until accepted)
//   result               : sum/difference modulo 2^DATA_WIDTH
//   carry_out            : carry out of the MSB stage (for sub, 1 means no borrow)
//   overflow             : signed overflow (carry into MSB xor carry out of MSB)
module serial_addsub
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    addsub_state_t         state;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [CNT_W-1:0]      cnt;
    logic                  carry;

    logic fa_s;
    logic fa_cout;

    // One adder stage, reused every cycle on the bit selected by cnt.
    full_adder u_fa (
        .a    (a_reg[cnt]),
        .b    (b_reg[cnt]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Control FSM, bit counter and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b ^ {DATA_WIDTH{sub}};
                        carry    <= sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands in place after the last step.
                    result <= {fa_s, result[DATA_WIDTH-1:1]};
                    carry  <= fa_cout;
                    if (cnt == LAST_BIT) begin
                        // carry currently holds the carry into the MSB stage.
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (DATA_WIDTH = 8): directed cases,
// backpressure, mid-operation reset and a random back-to-back stream
// compared against an arithmetic reference model.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;

    int n_cmp;
    int n_bad;

    serial_addsub #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {overflow, carry_out, result} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int sx;
        int sy;
        int ux;
        int uy;
        int sr;
        logic       ov;
        logic       co;
        logic [7:0] r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        sr = s ? (sx - sy) : (sx + sy);
        ov = (sr > 127) || (sr < -128);
        co = s ? (ux >= uy) : ((ux + uy) > 255);
        r  = 8'(s ? (ux - uy) : (ux + uy));
        return {ov, co, r};
    endfunction

    // One operation with optional hold cycles of backpressure in DONE.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic ts, input int hold);
        logic [9:0] e;
        int lat;
        e = model(ta, tb, ts);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(lat), 32'd9);
        check({tag, ".result"}, 32'(result), 32'(e[7:0]));
        check({tag, ".carry_out"}, 32'(carry_out), 32'(e[8]));
        check({tag, ".overflow"}, 32'(overflow), 32'(e[9]));
        for (int i = 0; i < hold; i++) begin
            // New operands offered while busy must be ignored.
            in_valid = (i % 2 == 0);
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_result"}, 32'({overflow, carry_out, result}), 32'(e));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".release_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".release_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Mid-SHIFT reset: outputs return to reset values at once and no result appears.
    task automatic reset_mid_shift();
        int seen;
        @(negedge clk);
        a = 8'h55; b = 8'h0A; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.result", 32'(result), 32'd0);
        check("rst_mid.carry_ovf", 32'({carry_out, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid.no_out_valid", 32'(seen), 32'd0);
        check("rst_mid.idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    // Continuous stream: in_valid and out_ready held high, random operands every cycle.
    task automatic stream(input int n_ops);
        logic [9:0] exp_q[$];
        logic [9:0] e;
        int cyc;
        int prev;
        int done;
        prev = -1;
        done = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (done < n_ops && cyc < 20 * n_ops) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream.unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream.result", 32'(result), 32'(e[7:0]));
                    check("stream.carry_out", 32'(carry_out), 32'(e[8]));
                    check("stream.overflow", 32'(overflow), 32'(e[9]));
                end
                if (prev >= 0) check("stream.interval", 32'(cyc - prev), 32'd10);
                prev = cyc;
                done++;
            end
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            if (in_ready) exp_q.push_back(model(a, b, sub));
        end
        check("stream.completed", 32'(done), 32'(n_ops));
        in_valid = 1'b0;
        out_ready = 1'b0;
        // Drain any op still in flight.
        repeat (12) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.carry_ovf", 32'({carry_out, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // out_ready while idle has no effect.
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.out_ready_ignored", 32'({in_ready, out_valid}), 32'b10);
        out_ready = 1'b0;

        reset_mid_shift();
        run_op("add_12_34", 8'h12, 8'h34, 1'b0, 0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 0);
        run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 0);
        run_op("sub_00_00", 8'h00, 8'h00, 1'b1, 0);
        run_op("backpressure", 8'hC3, 8'h5A, 1'b1, 5);
        stream(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_addsub
